// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   NUM_DIGITOS   : digits on the display
//   ANODOS_OFF    : anode pattern with every digit dark (anodes are active low)
//   DIV_DEF       : default clock cycles per digit slot
//   BLANK_CYC_DEF : default dark cycles at the start of each slot
//   estado_t      : scan FSM encoding
//   digito()      : extracts BCD digit idx from a 16-bit value
package display_pkg;

    localparam int         NUM_DIGITOS   = 4;
    localparam logic [3:0] ANODOS_OFF    = 4'b1111;
    localparam int         DIV_DEF       = 50000;
    localparam int         BLANK_CYC_DEF = 2;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } estado_t;

    function automatic logic [3:0] digito(input logic [15:0] v, input logic [1:0] idx);
        logic [15:0] desplazado;
        desplazado = v >> {idx, 2'b00};
        return desplazado[3:0];
    endfunction

endpackage

// File: rtl/control_display_if.sv
// Bundle between the display controller and its user.
//   valor     : four BCD digits, [3:0] is the rightmost digit
//   cargar    : single-cycle load strobe for valor
//   suprimir  : blank leading zeros
//   pendiente : a loaded value is waiting for the next frame boundary
//   numero    : digit code to the registered segment decoder
//   anodos    : active-low anode enables, bit 0 is digit 0
// master = user side, slave = controller side.
interface control_display_if;
    import display_pkg::*;

    logic [15:0]            valor;
    logic                   cargar;
    logic                   suprimir;
    logic                   pendiente;
    logic [3:0]             numero;
    logic [NUM_DIGITOS-1:0] anodos;

    modport master (
        output valor, cargar, suprimir,
        input  pendiente, numero, anodos
    );

    modport slave (
        input  valor, cargar, suprimir,
        output pendiente, numero, anodos
    );

endinterface

// File: rtl/divisor_refresco.sv
// Slot timer for the display scan.
//   CLK, RESET : clock, asynchronous active-high reset
//   cuenta_o   : position within the current slot, 0..DIV-1
//   fin_slot_o : high on the last cycle of each slot (the wrap cycle)
module divisor_refresco
    import display_pkg::*;
#(
    parameter int DIV = DIV_DEF,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic [CW-1:0] cuenta_o,
    output logic          fin_slot_o
);

    localparam logic [CW-1:0] ULTIMO = CW'(DIV - 1);

    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] cuenta_d;

    assign fin_slot_o = (cuenta_q == ULTIMO);
    assign cuenta_d   = fin_slot_o ? '0 : cuenta_q + 1'b1;
    assign cuenta_o   = cuenta_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/control_display.sv
// Time-multiplexed scan controller for a four-digit seven-segment display.
// Holds the displayed value plus a shadow register so that updates only take
// effect at a frame boundary (digit 3 -> digit 0), never mid-scan.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : control_display_if.slave (valor/cargar/suprimir in,
//                pendiente/numero/anodos out)
//
// state | meaning
// BLANK | slot start, all anodes off while the decoder settles on numero
// SHOW  | anode of the current digit on (unless suppressed)
module control_display
    import display_pkg::*;
#(
    parameter int DIV       = DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    control_display_if.slave    bus
);

    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] FIN_BLANK = CW'(BLANK_CYC - 1);

    logic [CW-1:0]          cuenta;
    logic                   fin_slot;
    logic                   frontera;

    estado_t                estado_q, estado_d;
    logic [1:0]             indice_q, indice_d;
    logic [15:0]            activo_q, activo_d;
    logic [15:0]            sombra_q, sombra_d;
    logic                   pendiente_q, pendiente_d;
    logic [3:0]             numero_q, numero_d;
    logic [NUM_DIGITOS-1:0] encendido;
    logic [NUM_DIGITOS-1:0] anodos_c;

    divisor_refresco #(
        .DIV (DIV),
        .CW  (CW)
    ) u_divisor (
        .CLK        (CLK),
        .RESET      (RESET),
        .cuenta_o   (cuenta),
        .fin_slot_o (fin_slot)
    );

    assign frontera = fin_slot && (indice_q == 2'd3);

    // A digit above the leading non-zero one stays dark; digit 0 is always lit.
    assign encendido[0] = 1'b1;
    assign encendido[1] = ~bus.suprimir | (|activo_q[15:4]);
    assign encendido[2] = ~bus.suprimir | (|activo_q[15:8]);
    assign encendido[3] = ~bus.suprimir | (|activo_q[15:12]);

    always_comb begin
        indice_d    = fin_slot ? indice_q + 2'd1 : indice_q;
        activo_d    = activo_q;
        sombra_d    = sombra_q;
        pendiente_d = pendiente_q;

        if (frontera && pendiente_q) begin
            activo_d    = sombra_q;
            pendiente_d = 1'b0;
        end

        // A load on the boundary cycle bypasses the shadow and wins over it.
        if (bus.cargar) begin
            sombra_d = bus.valor;
            if (frontera) begin
                activo_d    = bus.valor;
                pendiente_d = 1'b0;
            end else begin
                pendiente_d = 1'b1;
            end
        end

        // Loaded at the wrap using next-cycle index/value, so the new code is
        // present on the first BLANK cycle and the decoder settles before SHOW.
        numero_d = fin_slot ? digito(activo_d, indice_d) : numero_q;
    end

    always_comb begin
        estado_d = estado_q;
        anodos_c = ANODOS_OFF;
        case (estado_q)
            BLANK: begin
                if (cuenta == FIN_BLANK) begin
                    estado_d = SHOW;
                end
            end
            SHOW: begin
                if (encendido[indice_q]) begin
                    anodos_c = ~(4'b0001 << indice_q);
                end
                if (fin_slot) begin
                    estado_d = BLANK;
                end
            end
            default: estado_d = BLANK;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado_q    <= BLANK;
            indice_q    <= 2'd0;
            activo_q    <= 16'h0000;
            sombra_q    <= 16'h0000;
            pendiente_q <= 1'b0;
            numero_q    <= 4'h0;
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            activo_q    <= activo_d;
            sombra_q    <= sombra_d;
            pendiente_q <= pendiente_d;
            numero_q    <= numero_d;
        end
    end

    assign bus.anodos    = anodos_c;
    assign bus.numero    = numero_q;
    assign bus.pendiente = pendiente_q;

endmodule
